// File: rtl/otter_timer_pkg.sv
// otter_timer_pkg
// Shared constants for the OTTER interrupt timer: default register window
// base, register byte offsets inside the 16-byte window, CTRL bit positions,
// the unpacked CTRL register type and a helper that builds the CTRL readback
// word.
package otter_timer_pkg;

  localparam logic [31:0] TMR_BASE_ADDR_DEFAULT = 32'h1100_0300;

  // Byte offsets within the window; address bits [1:0] are never decoded.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IE_BIT       = 1;
  localparam int CTRL_ONESHOT_BIT  = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;

  localparam int STATUS_PENDING_BIT = 0;

  typedef struct packed {
    logic [7:0] prescale;
    logic       oneshot;
    logic       ie;
    logic       en;
  } tmr_ctrl_t;

  // CTRL readback: unimplemented bits always read as zero.
  function automatic logic [31:0] ctrl_pack(input tmr_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                             = c.en;
    w[CTRL_IE_BIT]                             = c.ie;
    w[CTRL_ONESHOT_BIT]                        = c.oneshot;
    w[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]     = c.prescale;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides CLK by PRESCALE+1 while enabled. The internal count runs
// 0..PRESCALE and TICK pulses for one cycle when it equals PRESCALE.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset
//   EN        in   count enable; count held at 0 while low
//   CLR       in   synchronous restart (CTRL write); also masks TICK
//   PRESCALE  in   terminal value of the count
//   TICK      out  one-cycle pulse, once every PRESCALE+1 enabled cycles
module timer_prescaler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       CLR,
  input  logic [7:0] PRESCALE,
  output logic       TICK
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // A CTRL write restarts the period, so a tick landing on that same cycle
  // is dropped; this also keeps a oneshot disable from racing a CTRL write.
  assign TICK = EN & ~CLR & (cnt_q == PRESCALE);

  always_comb begin
    cnt_d = cnt_q;
    if (!EN || CLR) begin
      cnt_d = '0;
    end else if (cnt_q == PRESCALE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/otter_timer_intr.sv
// otter_timer_intr
// Memory-mapped down-counting timer with a level interrupt for the OTTER MCU.
// Registers (word offsets in a 16-byte window at BASE_ADDR):
//   +0x0 CTRL    bit0 EN, bit1 IE, bit2 ONESHOT, bits[15:8] PRESCALE
//   +0x4 LOAD    reload value
//   +0x8 COUNT   current count (writable)
//   +0xC STATUS  bit0 PENDING, write 1 to clear
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   IOBUS_ADDR  in   bus address
//   IOBUS_OUT   in   bus write data
//   IOBUS_WR    in   one-cycle write strobe
//   TMR_DOUT    out  combinational read data, 0 when not selected
//   TMR_SEL     out  address falls inside the register window
//   INTR        out  PENDING & IE, driven only from flops
module otter_timer_intr
  import otter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TMR_BASE_ADDR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] TMR_DOUT,
  output logic        TMR_SEL,
  output logic        INTR
);

  tmr_ctrl_t   ctrl_q;
  tmr_ctrl_t   ctrl_d;
  logic [31:0] load_q;
  logic [31:0] load_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        pending_q;
  logic        pending_d;

  logic [3:0]  reg_off;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic        tick;
  logic        expire;
  logic        addr_unused;

  // Byte lanes are not decoded; sub-word addresses alias to the word.
  assign addr_unused = ^IOBUS_ADDR[1:0];
  assign reg_off     = {IOBUS_ADDR[3:2], 2'b00};

  assign TMR_SEL   = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = IOBUS_WR & TMR_SEL;
  assign wr_ctrl   = wr_en & (reg_off == OFF_CTRL);
  assign wr_load   = wr_en & (reg_off == OFF_LOAD);
  assign wr_count  = wr_en & (reg_off == OFF_COUNT);
  assign wr_status = wr_en & (reg_off == OFF_STATUS);

  timer_prescaler u_prescaler (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (ctrl_q.en),
    .CLR      (wr_ctrl),
    .PRESCALE (ctrl_q.prescale),
    .TICK     (tick)
  );

  // Expiry is a tick that finds the count already at zero, so the period
  // is LOAD+1 ticks and LOAD=0 expires on every tick.
  assign expire = tick & (count_q == 32'd0);

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (wr_ctrl) begin
      ctrl_d.en       = IOBUS_OUT[CTRL_EN_BIT];
      ctrl_d.ie       = IOBUS_OUT[CTRL_IE_BIT];
      ctrl_d.oneshot  = IOBUS_OUT[CTRL_ONESHOT_BIT];
      ctrl_d.prescale = IOBUS_OUT[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
    end else if (expire && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end

    if (wr_load) begin
      load_d = IOBUS_OUT;
    end

    // Decrement is guarded by the zero test, so the count never wraps.
    if (tick) begin
      count_d = expire ? load_q : (count_q - 32'd1);
    end
    if (wr_count) begin
      count_d = IOBUS_OUT;
    end

    // Hardware set is applied after the software clear so it wins a tie.
    if (wr_status && IOBUS_OUT[STATUS_PENDING_BIT]) begin
      pending_d = 1'b0;
    end
    if (expire) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    TMR_DOUT = '0;
    if (TMR_SEL) begin
      case (reg_off)
        OFF_CTRL:   TMR_DOUT = ctrl_pack(ctrl_q);
        OFF_LOAD:   TMR_DOUT = load_q;
        OFF_COUNT:  TMR_DOUT = count_q;
        OFF_STATUS: TMR_DOUT = {31'd0, pending_q};
        default:    TMR_DOUT = '0;
      endcase
    end
  end

  assign INTR = pending_q & ctrl_q.ie;

endmodule

// File: doc/otter_timer_intr.md
OTTER_TIMER_INTR -- requirements
Module: otter_timer_intr

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1100_0300, the word-aligned base of its 16-byte register window.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port IOBUS_ADDR  input  32  bus address from the MCU.
REQ-005 The block SHALL have port IOBUS_OUT  input  32  bus write data from the MCU.
REQ-006 The block SHALL have port IOBUS_WR  input  1  bus write strobe, one cycle per store.
REQ-007 The block SHALL have port TMR_DOUT  output  32  read data for the addressed register, 0 when not selected.
REQ-008 The block SHALL have port TMR_SEL  output  1  high when IOBUS_ADDR falls inside the window, used by the IOBUS_IN read mux.
REQ-009 The block SHALL have port INTR  output  1  level interrupt request to the MCU INTR input.

Function
REQ-010 The register map SHALL be CTRL +0x0, LOAD +0x4, COUNT +0x8, STATUS +0xC; IOBUS_ADDR[1:0] SHALL be ignored.
REQ-011 CTRL fields SHALL be: bit0 EN, bit1 IE, bit2 ONESHOT, bits[15:8] PRESCALE; all other bits read 0.
REQ-012 TMR_SEL and TMR_DOUT SHALL be combinational from IOBUS_ADDR and register state, with zero-cycle read latency.
REQ-013 A write SHALL take effect on the CLK edge where IOBUS_WR=1 and TMR_SEL=1; writes outside the window SHALL be ignored.
REQ-014 The prescaler SHALL count 0..PRESCALE while EN=1 and emit a one-cycle tick on the cycle it equals PRESCALE, then return to 0, so one tick occurs every PRESCALE+1 cycles.
REQ-015 The prescaler SHALL clear to 0 while EN=0 and on any CTRL write.
REQ-016 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-017 On a tick with COUNT == 0, the block SHALL set PENDING and reload COUNT from LOAD.
REQ-018 In that same case, if ONESHOT=1 the block SHALL also clear EN.
REQ-019 LOAD=0 with EN=1 SHALL set PENDING on every tick.
REQ-020 A software write to COUNT SHALL override a same-cycle tick decrement or reload.
REQ-021 STATUS bit0 SHALL read PENDING, and a write with bit0=1 SHALL clear it.
REQ-022 If a hardware set and a software clear of PENDING occur in the same cycle, the set SHALL win.
REQ-023 INTR SHALL equal PENDING & IE and SHALL be registered-state driven, with no combinational path from IOBUS inputs.
REQ-024 PENDING SHALL be set regardless of IE, so clearing IE masks INTR without losing the event.
REQ-025 COUNT wrap-around below zero SHALL never occur; 32-bit arithmetic SHALL be unsigned.

Reset
REQ-026 While RST=1, CTRL, LOAD, COUNT, PENDING and the prescaler SHALL be 0.
REQ-027 While RST=1, INTR SHALL be 0, and TMR_DOUT SHALL reflect the zeroed registers.
REQ-028 A reset asserted mid-count SHALL abort the count immediately, without waiting for a clock edge.
REQ-029 After RST deasserts, the timer SHALL remain idle until software sets EN.

Structure
REQ-030 Register offsets, CTRL bit positions and the default BASE_ADDR SHALL live in shared package otter_timer_pkg.
REQ-031 The prescaler SHALL be the single sub-module timer_prescaler, with inputs CLK, RST, EN, CLR and PRESCALE[7:0] and output TICK.
REQ-032 All remaining logic SHALL reside in otter_timer_intr.

Verification
REQ-033 Scenario: LOAD=3, PRESCALE=0, CTRL=0x3 -> COUNT reads 3,2,1,0 on successive cycles; PENDING and INTR rise on the 4th tick; COUNT reloads to 3.
REQ-034 Scenario: PRESCALE=4, LOAD=1, EN=1 -> ticks occur every 5 cycles; INTR asserts 10 cycles after the enable write.
REQ-035 Scenario: ONESHOT=1, LOAD=2 -> exactly one PENDING event occurs and CTRL reads EN=0 afterwards; COUNT holds at 2.
REQ-036 Scenario: write STATUS=1 on the same cycle as an expiry -> PENDING stays 1; a subsequent STATUS=1 write clears it and INTR drops the next cycle.
REQ-037 Scenario: IE=0 with an expiry -> INTR stays 0 and STATUS reads 1; then writing IE=1 raises INTR on the following cycle.
REQ-038 Scenario: RST pulsed mid-count with COUNT=7 -> all registers read 0 and INTR=0 before the next CLK edge; a write to 0x1100_0400 changes nothing and TMR_SEL=0.
